// File: rtl/chirp_sweep_gen_pkg.sv
// Shared definitions for the chirp sweep controller: widths, state encoding
// and the default sweep profile used by board-level tops.
package chirp_sweep_gen_pkg;

    localparam int PHI_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Default sweep profile at PHI_W_DEF bits
    localparam logic [PHI_W_DEF-1:0] DEF_START = 32'd42950;
    localparam logic [PHI_W_DEF-1:0] DEF_STEP  = 32'd439883;
    localparam logic [PHI_W_DEF-1:0] DEF_STOP  = 32'd429926226;

endpackage

// File: rtl/chirp_sweep_gen_if.sv
// Control/config and output bundle of the chirp sweep controller.
interface chirp_sweep_gen_if
    import chirp_sweep_gen_pkg::*;
#(
    parameter int N_CH    = 8,
    parameter int PHI_W   = PHI_W_DEF,
    parameter int DWELL_W = 24
);

    logic                    start;
    logic                    abort;
    logic                    enable;
    logic                    cfg_oneshot;
    logic [PHI_W-1:0]        cfg_start;
    logic [PHI_W-1:0]        cfg_step;
    logic [PHI_W-1:0]        cfg_stop;
    logic [DWELL_W-1:0]      cfg_dwell;
    logic [N_CH*PHI_W-1:0]   phi_inc;
    logic                    phi_valid;
    logic                    busy;
    logic                    sweep_wrap;
    logic [15:0]             sweep_cnt;

    modport master (
        output start, abort, enable, cfg_oneshot,
        output cfg_start, cfg_step, cfg_stop, cfg_dwell,
        input  phi_inc, phi_valid, busy, sweep_wrap, sweep_cnt
    );

    modport slave (
        input  start, abort, enable, cfg_oneshot,
        input  cfg_start, cfg_step, cfg_stop, cfg_dwell,
        output phi_inc, phi_valid, busy, sweep_wrap, sweep_cnt
    );

endinterface

// File: rtl/chirp_sweep_gen_chan_offset.sv
// Registered adder bank: maps the shared base increment to N_CH packed
// per-channel increments and aligns phi_valid with them.
module chirp_chan_offset
    import chirp_sweep_gen_pkg::*;
#(
    parameter int N_CH      = 8,
    parameter int PHI_W     = PHI_W_DEF,
    parameter int CH_OFFSET = 1000
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic [PHI_W-1:0]      base,
    input  logic                  active,
    input  logic                  flush,
    output logic [N_CH*PHI_W-1:0] phi_inc,
    output logic                  phi_valid
);

    logic [N_CH*PHI_W-1:0] phi_next;

    // Channel offsets fold to constants; sums truncate modulo 2^PHI_W
    always_comb begin
        phi_next = '0;
        for (int k = 0; k < N_CH; k++) begin
            phi_next[k*PHI_W +: PHI_W] = base + PHI_W'(k * CH_OFFSET);
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            phi_inc   <= '0;
            phi_valid <= 1'b0;
        end else if (flush || !active) begin
            phi_inc   <= '0;
            phi_valid <= 1'b0;
        end else begin
            phi_inc   <= phi_next;
            phi_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/chirp_sweep_gen.sv
// Multi-channel linear chirp controller: steps a shared base increment every
// dwell period, wraps it at a threshold and fans it out per channel.
module chirp_sweep_gen
    import chirp_sweep_gen_pkg::*;
#(
    parameter int N_CH      = 8,
    parameter int PHI_W     = PHI_W_DEF,
    parameter int DWELL_W   = 24,
    parameter int CH_OFFSET = 1000
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    chirp_sweep_gen_if.slave bus
);

    state_t               state_q;
    logic [PHI_W-1:0]     base_q;
    logic [DWELL_W-1:0]   count_q;
    logic                 sh_oneshot;
    logic [PHI_W-1:0]     sh_start;
    logic [PHI_W-1:0]     sh_step;
    logic [PHI_W-1:0]     sh_stop;
    logic [DWELL_W-1:0]   sh_dwell;
    logic                 sweep_wrap_q;
    logic [15:0]          sweep_cnt_q;

    logic [PHI_W:0]       sum;
    logic                 wrap_hit;
    logic [DWELL_W-1:0]   last_cnt;

    // A dwell of zero behaves as one cycle per step
    assign last_cnt = (sh_dwell == '0) ? '0 : sh_dwell - 1'b1;
    assign sum      = {1'b0, base_q} + {1'b0, sh_step};
    assign wrap_hit = sum[PHI_W] || (sum >= {1'b0, sh_stop});

    // Abort beats start; start restarts from any state; enable gates counting
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            count_q      <= '0;
            sh_oneshot   <= 1'b0;
            sh_start     <= '0;
            sh_step      <= '0;
            sh_stop      <= '0;
            sh_dwell     <= '0;
            sweep_wrap_q <= 1'b0;
            sweep_cnt_q  <= '0;
        end else begin
            sweep_wrap_q <= 1'b0;
            if (bus.abort) begin
                state_q <= ST_IDLE;
                count_q <= '0;
            end else if (bus.start) begin
                sh_oneshot <= bus.cfg_oneshot;
                sh_start   <= bus.cfg_start;
                sh_step    <= bus.cfg_step;
                sh_stop    <= bus.cfg_stop;
                sh_dwell   <= bus.cfg_dwell;
                base_q     <= bus.cfg_start;
                count_q    <= '0;
                state_q    <= ST_RUN;
            end else if (state_q != ST_IDLE) begin
                state_q <= bus.enable ? ST_RUN : ST_PAUSE;
                if (bus.enable) begin
                    if (count_q == last_cnt) begin
                        count_q <= '0;
                        if (wrap_hit) begin
                            sweep_wrap_q <= 1'b1;
                            sweep_cnt_q  <= sweep_cnt_q + 16'd1;
                            if (sh_oneshot) begin
                                state_q <= ST_IDLE;
                            end else begin
                                base_q <= sh_start;
                            end
                        end else begin
                            base_q <= sum[PHI_W-1:0];
                        end
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.sweep_wrap = sweep_wrap_q;
    assign bus.sweep_cnt  = sweep_cnt_q;

    chirp_chan_offset #(
        .N_CH      (N_CH),
        .PHI_W     (PHI_W),
        .CH_OFFSET (CH_OFFSET)
    ) u_chan_offset (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .base      (base_q),
        .active    (state_q != ST_IDLE),
        .flush     (bus.abort),
        .phi_inc   (bus.phi_inc),
        .phi_valid (bus.phi_valid)
    );

endmodule

// File: tb/tb_chirp_sweep_gen.sv
// Scoreboard bench for chirp_sweep_gen: per-cycle expected outputs are queued
// with the stimulus and compared at the falling edge.
module tb_chirp_sweep_gen;

    localparam int N_CH    = 8;
    localparam int PHI_W   = 32;
    localparam int DWELL_W = 24;

    typedef struct packed {
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] p7;
        logic        valid;
        logic        busy;
        logic        wrap;
        logic [15:0] cnt;
    } obs_t;

    logic sys_clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];

    chirp_sweep_gen_if #(.N_CH(N_CH), .PHI_W(PHI_W), .DWELL_W(DWELL_W)) bus ();

    chirp_sweep_gen #(
        .N_CH(N_CH), .PHI_W(PHI_W), .DWELL_W(DWELL_W), .CH_OFFSET(1000)
    ) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic obs_t observe();
        obs_t o;
        o.p0    = bus.phi_inc[0*PHI_W +: PHI_W];
        o.p1    = bus.phi_inc[1*PHI_W +: PHI_W];
        o.p7    = bus.phi_inc[7*PHI_W +: PHI_W];
        o.valid = bus.phi_valid;
        o.busy  = bus.busy;
        o.wrap  = bus.sweep_wrap;
        o.cnt   = bus.sweep_cnt;
        return o;
    endfunction

    // Expected outputs; idle channels are all zero, active ones are spaced by 1000
    function automatic obs_t mk(logic [31:0] p0, logic valid, logic busy,
                                logic wrap, logic [15:0] cnt);
        obs_t o;
        o.p0    = valid ? p0 : 32'd0;
        o.p1    = valid ? p0 + 32'd1000 : 32'd0;
        o.p7    = valid ? p0 + 32'd7000 : 32'd0;
        o.valid = valid;
        o.busy  = busy;
        o.wrap  = wrap;
        o.cnt   = cnt;
        return o;
    endfunction

    function automatic void show_fail(string name, int c, obs_t got, obs_t req);
        $display("[TB] FAIL %s cycle %0d: got p0=%h p1=%h p7=%h valid=%b busy=%b wrap=%b cnt=%0d, expected p0=%h p1=%h p7=%h valid=%b busy=%b wrap=%b cnt=%0d",
                 name, c, got.p0, got.p1, got.p7, got.valid, got.busy, got.wrap, got.cnt,
                 req.p0, req.p1, req.p7, req.valid, req.busy, req.wrap, req.cnt);
    endfunction

    task automatic set_cfg(logic oneshot, logic [31:0] s, logic [31:0] st,
                           logic [31:0] sp, logic [23:0] dw);
        bus.cfg_oneshot = oneshot;
        bus.cfg_start   = s;
        bus.cfg_step    = st;
        bus.cfg_stop    = sp;
        bus.cfg_dwell   = dw;
    endtask

    task automatic go_idle();
        @(negedge sys_clk);
        bus.abort = 1'b1;
        bus.start = 1'b0;
        bus.enable = 1'b1;
        @(negedge sys_clk);
        bus.abort = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        obs_t obs, e;
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 3; c++) sb.push_back(mk(0, 0, 0, 0, 0));
        for (int c = 1; c <= 3; c++) begin
            @(negedge sys_clk);
            obs = observe();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; show_fail("reset", c, obs, e); end
        end
    endtask

    task automatic test_basic_step();
        obs_t obs, e;
        @(negedge sys_clk);
        set_cfg(0, 100, 10, 1000, 4);
        bus.start = 1'b1;
        for (int c = 1; c <= 11; c++)
            sb.push_back(mk(c < 2 ? 0 : c < 6 ? 100 : c < 10 ? 110 : 120, c >= 2, 1, 0, 0));
        for (int c = 1; c <= 11; c++) begin
            @(negedge sys_clk);
            obs = observe();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; show_fail("basic_step", c, obs, e); end
            bus.start = 1'b0;
        end
    endtask

    task automatic test_continuous_wrap();
        obs_t obs, e;
        logic [31:0] p;
        @(negedge sys_clk);
        set_cfg(0, 100, 300, 1000, 1);
        bus.start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            p = ((c - 2) % 3 == 0) ? 100 : ((c - 2) % 3 == 1) ? 400 : 700;
            sb.push_back(mk(c < 2 ? 0 : p, c >= 2, 1, (c >= 4) && ((c - 1) % 3 == 0),
                            16'((c - 1) / 3)));
        end
        sb.push_back(mk(0, 0, 0, 0, 3));
        for (int c = 1; c <= 12; c++) begin
            @(negedge sys_clk);
            obs = observe();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; show_fail("continuous_wrap", c, obs, e); end
            bus.start = 1'b0;
            bus.abort = (c == 11);
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_oneshot();
        obs_t obs, e;
        @(negedge sys_clk);
        set_cfg(1, 100, 300, 1000, 1);
        bus.start = 1'b1;
        sb.push_back(mk(0,   0, 1, 0, 3));
        sb.push_back(mk(100, 1, 1, 0, 3));
        sb.push_back(mk(400, 1, 1, 0, 3));
        sb.push_back(mk(700, 1, 0, 1, 4));
        sb.push_back(mk(0,   0, 0, 0, 4));
        sb.push_back(mk(0,   0, 0, 0, 4));
        for (int c = 1; c <= 6; c++) begin
            @(negedge sys_clk);
            obs = observe();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; show_fail("oneshot", c, obs, e); end
            bus.start = 1'b0;
        end
        bus.cfg_oneshot = 1'b0;
    endtask

    // Carry out of the adder forces the reload; dwell of 0 steps every cycle
    task automatic test_overflow_dwell0();
        obs_t obs, e;
        @(negedge sys_clk);
        set_cfg(0, 32'hFFFF_FF00, 32'h200, 32'hFFFF_FFFF, 0);
        bus.start = 1'b1;
        sb.push_back(mk(0, 0, 1, 0, 4));
        for (int c = 2; c <= 5; c++) sb.push_back(mk(32'hFFFF_FF00, 1, 1, 1, 16'(4 + c - 1)));
        sb.push_back(mk(0, 0, 0, 0, 8));
        for (int c = 1; c <= 6; c++) begin
            @(negedge sys_clk);
            obs = observe();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; show_fail("overflow_dwell0", c, obs, e); end
            bus.start = 1'b0;
            bus.abort = (c == 5);
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_pause();
        obs_t obs, e;
        @(negedge sys_clk);
        set_cfg(0, 100, 10, 1000, 4);
        bus.start = 1'b1;
        for (int c = 1; c <= 17; c++)
            sb.push_back(mk(c < 2 ? 0 : c < 13 ? 100 : c < 17 ? 110 : 120, c >= 2, 1, 0, 8));
        for (int c = 1; c <= 17; c++) begin
            @(negedge sys_clk);
            obs = observe();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; show_fail("pause", c, obs, e); end
            bus.start = 1'b0;
            if (c == 2) bus.enable = 1'b0;
            if (c == 9) bus.enable = 1'b1;
        end
    endtask

    task automatic test_abort_priority();
        obs_t obs, e;
        @(negedge sys_clk);
        set_cfg(0, 100, 10, 1000, 4);
        bus.start = 1'b1;
        for (int c = 1; c <= 11; c++)
            sb.push_back(mk(c < 2 ? 0 : c < 5 ? 100 : c < 9 ? 500 : 510,
                            (c >= 2) && (c <= 9), c <= 9, 0, 8));
        for (int c = 1; c <= 11; c++) begin
            @(negedge sys_clk);
            obs = observe();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; show_fail("abort_priority", c, obs, e); end
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (c == 3) begin
                bus.cfg_start = 500;
                bus.start = 1'b1;
            end
            if (c == 4) begin
                bus.cfg_start = 7;
                bus.cfg_step  = 99;
            end
            if (c == 9) begin
                bus.start = 1'b1;
                bus.abort = 1'b1;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        obs_t obs, e;
        @(negedge sys_clk);
        set_cfg(0, 100, 10, 1000, 4);
        bus.start = 1'b1;
        for (int c = 1; c <= 4; c++) sb.push_back(mk(c < 2 ? 0 : 100, c >= 2, 1, 0, 8));
        sb.push_back(mk(0, 0, 0, 0, 0));
        for (int c = 1; c <= 3; c++) sb.push_back(mk(0, 0, 0, 0, 0));
        for (int c = 1; c <= 4; c++) begin
            @(negedge sys_clk);
            obs = observe();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; show_fail("pre_reset", c, obs, e); end
            bus.start = 1'b0;
        end
        @(negedge sys_clk);
        #2 reset_n = 1'b0;
        #1;
        obs = observe();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; show_fail("async_reset", 5, obs, e); end
        @(negedge sys_clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge sys_clk);
            obs = observe();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; show_fail("post_reset_idle", c, obs, e); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.enable = 1'b1;
        set_cfg(0, 0, 0, 0, 0);
        $display("[TB] starting chirp_sweep_gen bench");
        test_reset();
        test_basic_step();
        go_idle();
        test_continuous_wrap();
        go_idle();
        test_oneshot();
        go_idle();
        test_overflow_dwell0();
        go_idle();
        test_pause();
        go_idle();
        test_abort_priority();
        go_idle();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
